ct_sequencer: RTL
=================

CT_SEQUENCER -- requirements
Module: ct_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4: width of operand memory address and of len; max run length 2^ADDR_W-1.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately.
REQ-004 start  in  1  request one compute run; sampled only in IDLE.
REQ-005 len  in  ADDR_W  number of MAC steps for the run; sampled with accepted start.
REQ-006 abort  in  1  synchronous cancel of a run in progress.
REQ-007 busy  out  1  high from the cycle after start acceptance until return to IDLE.
REQ-008 done  out  1  one-cycle pulse when results are captured.
REQ-009 mem_addr  out  ADDR_W  shared read address to weight and subject memories (synchronous read, 1-cycle latency).
REQ-010 ct_clear  out  1  drives CT clear (accumulators and calc registers).
REQ-011 w_en  out  1  operand gate; when 0 the datapath forces CT weight_out to 0.
REQ-012 calc_in_1..4  in  8 each  CT calc_out_1..4.
REQ-013 res_out_1..4  out  8 each  captured results.
REQ-014 result_valid  out  1  res_out_1..4 hold the result of the last completed run.

Function
REQ-015 States SHALL be IDLE, CLEAR, FEED, DRAIN, DONE; all outputs registered.
REQ-016 IDLE: start=1 and len!=0 -> CLEAR, len latched, result_valid <= 0; start with len=0 SHALL be ignored (no busy, no done).
REQ-017 CLEAR (1 cycle): ct_clear=1, w_en=0, mem_addr=0; -> FEED.
REQ-018 FEED (len cycles): ct_clear=0, mem_addr = 0,1,...,len-1 on consecutive cycles; after address len-1 -> DRAIN.
REQ-019 w_en SHALL be high exactly in the len cycles one cycle after each FEED address, i.e. while valid memory data sits at CT inputs; low at all other times.
REQ-020 DRAIN SHALL last 3 cycles (memory latency, accumulator, calc register); mem_addr held at len-1.
REQ-021 At the end of the last DRAIN cycle res_out_1..4 <= calc_in_1..4; next cycle state DONE with done=1, result_valid=1; DONE -> IDLE after 1 cycle.
REQ-022 Latency: start sampled at edge T0 -> done high during cycle T0+len+5; busy high for cycles T0+1 .. T0+len+5.
REQ-023 Arithmetic: controller does no arithmetic on results; CT 8-bit wrap-around (mod 256) passes through unchanged.
REQ-024 start while not IDLE SHALL be ignored; len changes after acceptance SHALL have no effect.
REQ-025 abort=1 in CLEAR/FEED/DRAIN: next cycle IDLE with ct_clear=1 for that one cycle, w_en=0, no done, res_out and result_valid keep pre-run values (result_valid already 0 from acceptance).
REQ-026 abort in IDLE or DONE SHALL be ignored; abort and start together in IDLE: start wins.
REQ-027 len=2^ADDR_W-1 SHALL complete with mem_addr reaching all-ones without wrap.
REQ-028 ct_clear SHALL be 0 in IDLE except the post-abort cycle.

Reset
REQ-029 Reset values: state IDLE, busy 0, done 0, mem_addr 0, w_en 0, ct_clear 1, result_valid 0, res_out_1..4 0.
REQ-030 First clock after reset release: ct_clear 0; reset mid-run discards the run without done.

Verification
REQ-031 len=4, weights all 2, subjects 1,2,3,4 per step in lanes 1..4 -> done at T0+9, res_out = 8,16,24,32, result_valid 1.
REQ-032 len=1, weight 255, subject 2 -> done at T0+6, res_out_1 = 254 (mod 256 wrap).
REQ-033 start with len=0 -> busy stays 0, no done; start pulsed during FEED of len=5 run -> single done at T0+10.
REQ-034 abort in FEED cycle 2 of len=6 run -> IDLE next cycle, ct_clear pulse, no done, res_out unchanged from prior run.
REQ-035 reset low during DRAIN -> all outputs at reset values immediately; new run afterward gives correct results.
REQ-036 len=15 back-to-back runs -> mem_addr 0..14, w_en exactly 15 cycles per run, second run result independent of first.

Source files
------------

// File: rtl/ct_sequencer.sv
// rtl/ct_sequencer.sv - Run sequencer for the CT MAC array: clears, feeds addresses, drains and captures results.
module ct_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic [7:0]        calc_in_1,
    input  logic [7:0]        calc_in_2,
    input  logic [7:0]        calc_in_3,
    input  logic [7:0]        calc_in_4,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ct_clear,
    output logic              w_en,
    output logic [7:0]        res_out_1,
    output logic [7:0]        res_out_2,
    output logic [7:0]        res_out_3,
    output logic [7:0]        res_out_4,
    output logic              result_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        drain_cnt, drain_cnt_n;
    logic              busy_n, done_n, clear_n, wen_n;
    logic              accept, aborting, capture, last_addr;

    assign accept    = (state == S_IDLE) && start && (len != '0);
    assign aborting  = abort && ((state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN));
    assign capture   = (state == S_DRAIN) && (drain_cnt == 2'd2) && !abort;
    assign last_addr = (mem_addr == (len_q - ADDR_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            drain_cnt <= 2'd0;
            len_q     <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            if (accept) begin
                len_q <= len;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = S_CLEAR;
            S_CLEAR: state_n = abort ? S_IDLE : S_FEED;
            S_FEED: begin
                if (abort)          state_n = S_IDLE;
                else if (last_addr) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                   state_n = S_IDLE;
                else if (drain_cnt == 2'd2)  state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    // w_en trails each FEED address by one cycle to match the memory read latency.
    always_comb begin
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        clear_n     = (state_n == S_CLEAR) || aborting;
        wen_n       = (state == S_FEED) && !abort;
        addr_n      = '0;
        drain_cnt_n = 2'd0;
        case (state_n)
            S_FEED:  addr_n = (state == S_FEED) ? mem_addr + ADDR_W'(1) : '0;
            S_DRAIN: begin
                addr_n      = mem_addr;
                drain_cnt_n = (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            end
            default: addr_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_addr     <= '0;
            ct_clear     <= 1'b1;
            w_en         <= 1'b0;
            result_valid <= 1'b0;
            res_out_1    <= 8'd0;
            res_out_2    <= 8'd0;
            res_out_3    <= 8'd0;
            res_out_4    <= 8'd0;
        end else begin
            busy     <= busy_n;
            done     <= done_n;
            mem_addr <= addr_n;
            ct_clear <= clear_n;
            w_en     <= wen_n;
            if (accept) begin
                result_valid <= 1'b0;
            end else if (capture) begin
                result_valid <= 1'b1;
            end
            if (capture) begin
                res_out_1 <= calc_in_1;
                res_out_2 <= calc_in_2;
                res_out_3 <= calc_in_3;
                res_out_4 <= calc_in_4;
            end
        end
    end

endmodule
